// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit-side blocks.
package i2s_pkg;

  typedef enum logic {ARB, FULL} state_t;

  localparam int DEF_DAT_WDTH   = 24;
  localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/i2s_tx_sched_if.sv
// Source-facing handshake bus plus the frame/load link to i2s_tx.
interface i2s_tx_sched_if #(
  parameter int DAT_WDTH = 24,
  parameter int NUM_SRC  = 4
);

  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC-1:0]          src_ready;
  logic [NUM_SRC-1:0]          src_en;
  logic [NUM_SRC*DAT_WDTH-1:0] src_left;
  logic [NUM_SRC*DAT_WDTH-1:0] src_right;
  logic                        load;
  logic [DAT_WDTH-1:0]         left_chan;
  logic [DAT_WDTH-1:0]         right_chan;

  modport master (
    output src_valid, src_en, src_left, src_right, load,
    input  src_ready, left_chan, right_chan
  );

  modport slave (
    input  src_valid, src_en, src_left, src_right, load,
    output src_ready, left_chan, right_chan
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;
  int            pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_sched.sv
// Shares the single i2s_tx frame slot among NUM_SRC requesters, one frame per load period.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter  int DAT_WDTH      = DEF_DAT_WDTH,
  parameter  int NUM_SRC       = 4,
  parameter  bit UNDERRUN_ZERO = 1'b1,
  localparam int IDX_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  i2s_tx_sched_if.slave             bus,
  input  logic                      mute,
  output logic [IDX_W-1:0]          active_src,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NUM_SRC-1:0]  gnt;
  logic [DAT_WDTH-1:0] left_q, right_q;
  logic [DAT_WDTH-1:0] left_d, right_d;
  logic                hs;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req     (bus.src_valid & bus.src_en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // ready is held low during reset so no source sees a phantom accept
  assign bus.src_ready = (state == ARB && rst_n) ? gnt : '0;
  assign hs            = (state == ARB) && (|(bus.src_valid & bus.src_ready));
  assign ptr_nxt       = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (hs) begin
      left_d  = bus.src_left[int'(gnt_idx) * DAT_WDTH +: DAT_WDTH];
      right_d = bus.src_right[int'(gnt_idx) * DAT_WDTH +: DAT_WDTH];
    end else if (state == FULL && bus.load && UNDERRUN_ZERO) begin
      left_d  = '0;
      right_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB;
      ptr            <= '0;
      active_src     <= '0;
      underrun_cnt   <= '0;
      left_q         <= '0;
      right_q        <= '0;
      bus.left_chan  <= '0;
      bus.right_chan <= '0;
    end else begin
      left_q         <= left_d;
      right_q        <= right_d;
      bus.left_chan  <= mute ? '0 : left_d;
      bus.right_chan <= mute ? '0 : right_d;
      case (state)
        ARB: begin
          // a load seen in ARB always means i2s_tx replayed stale contents
          if (bus.load && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
          if (hs) begin
            active_src <= gnt_idx;
            ptr        <= ptr_nxt;
            state      <= FULL;
          end
        end
        FULL: if (bus.load) state <= ARB;
      endcase
    end
  end

endmodule
